// File: rtl/issue_select.sv
// issue_select -- issue stage of the backend scheduler.
//
// Picks one ready scheduler row per cycle with round-robin priority and
// returns two feedback paths to the wakeup logic. The first is an immediate
// free of the granted row. The second is a per-FU clear line, broadcast
// max(lat,1) cycles after issue, that wakes the producer's dependants.
// Dispatch writes each row's FU class and latency.
//
// Ports:
//   clk, rst        clock; synchronous active-low reset
//   alloc_en/row/fu/lat
//                   dispatch write of one row (lat 0 behaves as 1)
//   request_vector  per-row ready requests from the wakeup logic
//   fu_ready        per-FU-class issue permission for this cycle
//   issue_valid/row/fu
//                   registered grant; row and fu are 0 when not valid
//   free_en, free_row_index
//                   copies of issue_valid / issue_row
//   clear_en, clear_lines
//                   bit fu*NUM_ROWS+row pulses when that producer completes
//   row_busy        row is allocated or still has a clear outstanding
module issue_select #(
  parameter int NUM_ROWS = 8,
  parameter int NUM_FUS  = 4,
  parameter int LAT_W    = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alloc_en,
  input  logic [$clog2(NUM_ROWS)-1:0]   alloc_row,
  input  logic [$clog2(NUM_FUS)-1:0]    alloc_fu,
  input  logic [LAT_W-1:0]              alloc_lat,
  input  logic [NUM_ROWS-1:0]           request_vector,
  input  logic [NUM_FUS-1:0]            fu_ready,
  output logic                          issue_valid,
  output logic [$clog2(NUM_ROWS)-1:0]   issue_row,
  output logic [$clog2(NUM_FUS)-1:0]    issue_fu,
  output logic                          free_en,
  output logic [$clog2(NUM_ROWS)-1:0]   free_row_index,
  output logic                          clear_en,
  output logic [NUM_ROWS*NUM_FUS-1:0]   clear_lines,
  output logic [NUM_ROWS-1:0]           row_busy
);

  localparam int ROW_W = $clog2(NUM_ROWS);
  localparam int FU_W  = $clog2(NUM_FUS);

  // Per-row control state.
  logic [NUM_ROWS-1:0] alloc_q, alloc_d;
  logic [LAT_W-1:0]    cnt_q [NUM_ROWS];
  logic [LAT_W-1:0]    cnt_d [NUM_ROWS];
  // One-cycle clear pulse, registered when the row's counter reads 1.
  logic [NUM_ROWS-1:0] clr_q, clr_d;
  logic [ROW_W-1:0]    rr_ptr_q, rr_ptr_d;

  // Per-row payload written at dispatch.
  logic [FU_W-1:0]     fu_q  [NUM_ROWS];
  logic [LAT_W-1:0]    lat_q [NUM_ROWS];

  logic                issue_valid_q, issue_valid_d;
  logic [ROW_W-1:0]    issue_row_q, issue_row_d;
  logic [FU_W-1:0]     issue_fu_q, issue_fu_d;

  logic [NUM_ROWS-1:0] eligible;
  logic                grant_valid;
  logic [ROW_W-1:0]    grant_row;
  logic                hi_hit;
  logic [ROW_W-1:0]    hi_row, lo_row;
  logic [LAT_W-1:0]    alloc_lat_eff;

  // A latency of 0 is stored as 1 so the countdown always runs at least once.
  assign alloc_lat_eff = (alloc_lat == '0) ? LAT_W'(1) : alloc_lat;

  // Round-robin select. The scan runs from the top row down so that the
  // last hit is the lowest row. hi_* is the lowest eligible row at or above
  // rr_ptr. lo_* is the lowest eligible row overall, which is the wrap-around
  // choice when nothing sits at or above the pointer.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    eligible = '0;
    hi_hit   = 1'b0;
    hi_row   = '0;
    lo_row   = '0;
    grant_valid = 1'b0;
    for (int r = NUM_ROWS - 1; r >= 0; r--) begin
      eligible[r] = request_vector[r] & alloc_q[r] & fu_ready[fu_q[r]];
      if (eligible[r]) begin
        grant_valid = 1'b1;
        lo_row      = ROW_W'(r);
        if (ROW_W'(r) >= rr_ptr_q) begin
          hi_hit = 1'b1;
          hi_row = ROW_W'(r);
        end
      end
    end
    grant_row = hi_hit ? hi_row : lo_row;
  end

  // Next-state logic.
  always_comb begin
    alloc_d       = alloc_q;
    rr_ptr_d      = rr_ptr_q;
    clr_d         = '0;
    issue_valid_d = grant_valid;
    issue_row_d   = '0;
    issue_fu_d    = '0;
    cnt_d         = cnt_q;

    if (grant_valid) begin
      issue_row_d = grant_row;
      issue_fu_d  = fu_q[grant_row];
      rr_ptr_d    = (grant_row == ROW_W'(NUM_ROWS - 1)) ? '0 : grant_row + ROW_W'(1);
    end

    for (int r = 0; r < NUM_ROWS; r++) begin
      clr_d[r] = (cnt_q[r] == LAT_W'(1));
      if (cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - LAT_W'(1);
      end
      // A granted row is busy, so dispatch cannot target it in the same cycle.
      // The grant branch therefore never competes with the alloc branch.
      if (grant_valid && (grant_row == ROW_W'(r))) begin
        alloc_d[r] = 1'b0;
        cnt_d[r]   = lat_q[r];
      end else if (alloc_en && (alloc_row == ROW_W'(r))) begin
        alloc_d[r] = 1'b1;
      end
    end
  end

  // Control state. Reset drops every pending clear.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    if (!rst) begin
      alloc_q       <= '0;
      cnt_q         <= '{default: '0};
      clr_q         <= '0;
      rr_ptr_q      <= '0;
      issue_valid_q <= 1'b0;
      issue_row_q   <= '0;
      issue_fu_q    <= '0;
    end else begin
      alloc_q       <= alloc_d;
      cnt_q         <= cnt_d;
      clr_q         <= clr_d;
      rr_ptr_q      <= rr_ptr_d;
      issue_valid_q <= issue_valid_d;
      issue_row_q   <= issue_row_d;
      issue_fu_q    <= issue_fu_d;
    end
  end

  // Payload storage.
  always_ff @(posedge clk) begin
    // NOTE: the payload arrays are not reset. They are read only while alloc_q or clr_q qualifies the row.
    if (alloc_en) begin
      fu_q[alloc_row]  <= alloc_fu;
      lat_q[alloc_row] <= alloc_lat_eff;
    end
  end

  // Clear broadcast. fu_q stays stable through the pulse because the row is
  // still busy and cannot be reallocated.
  always_comb begin
    clear_lines = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (clr_q[r]) begin
        clear_lines[int'(fu_q[r]) * NUM_ROWS + r] = 1'b1;
      end
    end
  end

  // The clear pulse keeps the row busy for its final cycle, after the counter has hit 0.
  always_comb begin
    row_busy = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      row_busy[r] = alloc_q[r] | (cnt_q[r] != '0) | clr_q[r];
    end
  end

  assign clear_en       = |clear_lines;
  assign issue_valid    = issue_valid_q;
  assign issue_row      = issue_row_q;
  assign issue_fu       = issue_fu_q;
  assign free_en        = issue_valid_q;
  assign free_row_index = issue_row_q;

endmodule

// File: tb/tb_issue_select.sv
// Testbench for issue_select: directed scenarios followed by randomized
// traffic. A reference model steps on each rising edge and queues the
// expected grants and the expected clear vectors. A monitor on the falling
// edge compares them against the DUT outputs.
module tb_issue_select;

  localparam int NR  = 8;
  localparam int NF  = 4;
  localparam int CLW = NR * NF;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           alloc_en = 1'b0;
  logic [2:0]     alloc_row = '0;
  logic [1:0]     alloc_fu = '0;
  logic [2:0]     alloc_lat = '0;
  logic [NR-1:0]  request_vector = '0;
  logic [NF-1:0]  fu_ready = '0;
  logic           issue_valid;
  logic [2:0]     issue_row;
  logic [1:0]     issue_fu;
  logic           free_en;
  logic [2:0]     free_row_index;
  logic           clear_en;
  logic [CLW-1:0] clear_lines;
  logic [NR-1:0]  row_busy;

  issue_select #(.NUM_ROWS(NR), .NUM_FUS(NF), .LAT_W(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_en       (alloc_en),
    .alloc_row      (alloc_row),
    .alloc_fu       (alloc_fu),
    .alloc_lat      (alloc_lat),
    .request_vector (request_vector),
    .fu_ready       (fu_ready),
    .issue_valid    (issue_valid),
    .issue_row      (issue_row),
    .issue_fu       (issue_fu),
    .free_en        (free_en),
    .free_row_index (free_row_index),
    .clear_en       (clear_en),
    .clear_lines    (clear_lines),
    .row_busy       (row_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int row;
    int fu;
  } issue_t;

  bit             m_alloc [NR];
  int             m_fu [NR];
  int             m_lat [NR];
  int             m_busy_until [NR];   // last cycle in which the row stays busy
  int             m_rr = 0;
  int             cyc = 0;             // number of rising edges so far
  logic [CLW-1:0] clear_due [int];     // expected clear_lines keyed by cycle
  issue_t         exp_q [$];

  function automatic bit m_busy_at(input int r, input int c);
    return m_alloc[r] || (m_busy_until[r] >= c);
  endfunction

  always @(posedge clk) begin : model
    int g;
    int r;
    int lat_e;
    logic [CLW-1:0] bitv;
    issue_t it;
    cyc++;
    if (!rst) begin
      for (int i = 0; i < NR; i++) begin
        m_alloc[i]      = 1'b0;
        m_busy_until[i] = 0;
      end
      m_rr = 0;
      clear_due.delete();
    end else begin
      if (alloc_en) check("alloc_target_free", m_busy_at(int'(alloc_row), cyc - 1), 0);
      g = -1;
      for (int k = 0; k < NR; k++) begin
        r = (m_rr + k) % NR;
        if (g < 0 && request_vector[r] && m_alloc[r] && fu_ready[m_fu[r]]) g = r;
      end
      if (g >= 0) begin
        it.row = g;
        it.fu  = m_fu[g];
        exp_q.push_back(it);
        m_alloc[g] = 1'b0;
        m_rr  = (g + 1) % NR;
        lat_e = (m_lat[g] == 0) ? 1 : m_lat[g];
        bitv  = '0;
        bitv[m_fu[g] * NR + g] = 1'b1;
        if (clear_due.exists(cyc + lat_e)) clear_due[cyc + lat_e] |= bitv;
        else clear_due[cyc + lat_e] = bitv;
        m_busy_until[g] = cyc + lat_e;
      end
      if (alloc_en) begin
        m_alloc[alloc_row] = 1'b1;
        m_fu[alloc_row]    = int'(alloc_fu);
        m_lat[alloc_row]   = int'(alloc_lat);
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    issue_t e;
    logic [CLW-1:0] exp_clr;
    logic [NR-1:0]  exp_busy;
    if (cyc > 0) begin
      check("issue_valid", issue_valid, exp_q.size() != 0);
      check("free_en", free_en, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("issue_row", issue_row, e.row);
        check("issue_fu", issue_fu, e.fu);
        check("free_row_index", free_row_index, e.row);
      end else begin
        check("idle_fields_zero", {issue_row, issue_fu, free_row_index}, 0);
      end
      exp_clr = '0;
      if (clear_due.exists(cyc)) begin
        exp_clr = clear_due[cyc];
        clear_due.delete(cyc);
      end
      check("clear_lines", clear_lines, exp_clr);
      check("clear_en", clear_en, exp_clr != '0);
      for (int r = 0; r < NR; r++) exp_busy[r] = m_busy_at(r, cyc);
      check("row_busy", row_busy, exp_busy);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_alloc(input int r, input int fu, input int lat);
    alloc_en  = 1'b1;
    alloc_row = 3'(r);
    alloc_fu  = 2'(fu);
    alloc_lat = 3'(lat);
    tick();
    alloc_en  = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    tick(n);
    rst = 1'b1;
  endtask

  initial begin
    int free_rows [$];

    // Reset with every request high.
    rst = 1'b0;
    request_vector = '1;
    fu_ready = '1;
    tick(2);
    check("reset_row_busy", row_busy, 0);
    check("reset_issue_valid", issue_valid, 0);
    rst = 1'b1;
    request_vector = '0;
    tick();

    // Single issue: row 3, fu 2, lat 3.
    do_alloc(3, 2, 3);
    request_vector = 8'h08;
    tick();                                   // cycle C+1
    check("single_issue_row", issue_row, 3);
    request_vector = '0;
    tick(3);                                  // cycle C+4
    check("single_clear_bit19", clear_lines, 32'h0008_0000);
    tick();                                   // cycle C+5
    check("single_row3_free", row_busy[3], 0);
    tick(2);

    // Round-robin across rows 0, 2, 5.
    do_reset(1);
    do_alloc(0, 0, 1);
    do_alloc(2, 1, 2);
    do_alloc(5, 2, 1);
    request_vector = 8'h25;
    fu_ready = '1;
    tick(5);
    check("rr_ptr_final", dut.rr_ptr_q, 6);
    request_vector = '0;
    tick(3);

    // FU block: row 1 on fu 0 waits until fu_ready[0] rises.
    do_reset(1);
    do_alloc(1, 0, 2);
    do_alloc(4, 1, 2);
    request_vector = 8'h12;
    fu_ready = 4'b0010;
    tick();
    check("fu_block_first_row4", issue_row, 4);
    tick(2);
    fu_ready = 4'b1111;
    tick();
    check("fu_block_then_row1", issue_row, 1);
    request_vector = '0;
    tick(4);

    // Coincident clears from rows 0 and 6.
    do_reset(1);
    do_alloc(0, 0, 2);
    do_alloc(6, 3, 1);
    request_vector = 8'h01;
    tick();                                   // I
    request_vector = 8'h40;
    tick();                                   // I+1
    request_vector = '0;
    tick();                                   // I+2
    check("coincident_clears", clear_lines, 32'h4000_0001);
    tick(3);

    // Lat 0 and reset mid-countdown.
    do_reset(1);
    do_alloc(7, 1, 0);
    do_alloc(2, 0, 7);
    request_vector = 8'h80;
    tick();                                   // I
    request_vector = 8'h04;
    tick();                                   // I+1: row 7 clears
    request_vector = '0;
    tick();
    rst = 1'b0;
    tick();                                   // reset edge at I+3
    rst = 1'b1;
    check("midflight_busy_cleared", row_busy, 0);
    tick(12);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(99) != 0);
      request_vector = NR'($urandom);
      fu_ready = NF'($urandom);
      alloc_en = 1'b0;
      if (rst && $urandom_range(1) == 1) begin
        free_rows.delete();
        for (int r = 0; r < NR; r++) if (!m_busy_at(r, cyc)) free_rows.push_back(r);
        if (free_rows.size() != 0) begin
          alloc_en  = 1'b1;
          alloc_row = 3'(free_rows[$urandom_range(free_rows.size() - 1)]);
          alloc_fu  = 2'($urandom);
          alloc_lat = 3'($urandom);
        end
      end
      tick();
    end

    rst = 1'b1;
    alloc_en = 1'b0;
    request_vector = '0;
    tick(10);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
